// File: rtl/fp_mult_out_stage.sv
// Registered output stage for the fp_mult FP32 multiplier: canonicalises special
// results, buffers them in a 2-entry skid buffer, keeps sticky flags and optional
// exception counters (enabled with `define FP_OUT_CNT_EN).
module fp_mult_out_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_res,
  input  logic             in_exp_overflow,
  input  logic             in_nan,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [2:0]       out_flags,
  output logic [2:0]       sticky,
  input  logic             clr_sticky,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_nan,
  output logic [CNT_W-1:0] cnt_ovf,
  output logic [CNT_W-1:0] cnt_zero,
  output logic [CNT_W-1:0] cnt_total
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  // Priority nan > overflow > zero > pass; the sign survives overflow and zero.
  function automatic logic [DATA_W-1:0] canon(input logic [DATA_W-1:0] res,
                                              input logic nan, input logic ovf,
                                              input logic zero);
    if (nan)       canon = 32'h7FC0_0000;
    else if (ovf)  canon = {res[31], 8'hFF, 23'h0};
    else if (zero) canon = {res[31], 31'h0};
    else           canon = res;
  endfunction

  state_t            state, state_nxt;
  logic              acc, dlv;
  logic              load_main, main_from_skid, load_skid;
  logic [2:0]        in_flags;
  logic [DATA_W-1:0] in_canon;
  logic [DATA_W-1:0] skid_res;
  logic [2:0]        skid_flags;

  assign acc      = in_valid && in_ready;
  assign dlv      = out_valid && out_ready;
  assign in_flags = {in_nan, in_exp_overflow, in_zero};
  assign in_canon = canon(in_res, in_nan, in_exp_overflow, in_zero);

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (acc && dlv) begin
          load_main = 1'b1;
        end else if (acc) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (dlv) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (dlv) begin
          main_from_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Control and main register: in_ready/out_valid are registered from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_flags <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
      if (load_main) begin
        out_res   <= in_canon;
        out_flags <= in_flags;
      end else if (main_from_skid) begin
        out_res   <= skid_res;
        out_flags <= skid_flags;
      end
    end
  end

  // Skid register is only read in FULL, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_res   <= in_canon;
      skid_flags <= in_flags;
    end
  end

  // A set on accept wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0;
    end else if (acc) begin
      sticky <= (clr_sticky ? 3'b000 : sticky) | in_flags;
    end else if (clr_sticky) begin
      sticky <= '0;
    end
  end

`ifdef FP_OUT_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_nan   <= '0;
      cnt_ovf   <= '0;
      cnt_zero  <= '0;
      cnt_total <= '0;
    end else if (clr_cnt) begin
      cnt_nan   <= '0;
      cnt_ovf   <= '0;
      cnt_zero  <= '0;
      cnt_total <= '0;
    end else if (acc) begin
      cnt_total <= sat_inc(cnt_total);
      if (in_nan)          cnt_nan  <= sat_inc(cnt_nan);
      if (in_exp_overflow) cnt_ovf  <= sat_inc(cnt_ovf);
      if (in_zero)         cnt_zero <= sat_inc(cnt_zero);
    end
  end
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign cnt_nan   = '0;
  assign cnt_ovf   = '0;
  assign cnt_zero  = '0;
  assign cnt_total = '0;
`endif

endmodule

// File: tb/tb_fp_mult_out_stage.sv
// Scoreboard bench for fp_mult_out_stage: directed vectors push expected results,
// a negedge monitor pops and compares on every delivery.
module tb_fp_mult_out_stage;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_res = 32'hDEAD_BEEF;
  logic             in_exp_overflow = 1'b1;
  logic             in_nan = 1'b1;
  logic             in_zero = 1'b1;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_res;
  logic [2:0]       out_flags;
  logic [2:0]       sticky;
  logic             clr_sticky = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] cnt_nan, cnt_ovf, cnt_zero, cnt_total;

  fp_mult_out_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
    .in_exp_overflow(in_exp_overflow), .in_nan(in_nan), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_flags(out_flags), .sticky(sticky),
    .clr_sticky(clr_sticky), .clr_cnt(clr_cnt),
    .cnt_nan(cnt_nan), .cnt_ovf(cnt_ovf), .cnt_zero(cnt_zero), .cnt_total(cnt_total)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          run_len = 0;
  bit          prev_del = 1'b0;
  logic [34:0] sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int v);
`ifdef FP_OUT_CNT_EN
    exp_cnt = v;
`else
    exp_cnt = 0 * v;
`endif
  endfunction

  // Offer one result, push its expectation when it will be accepted, then idle the bus.
  task automatic send(input logic [31:0] res, input logic nan, input logic ovf,
                      input logic zero, input logic [31:0] exp_res);
    bit done = 1'b0;
    in_valid = 1'b1; in_res = res;
    in_nan = nan; in_exp_overflow = ovf; in_zero = zero;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back({exp_res, nan, ovf, zero});
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for res %h", res);
    end
    in_valid = 1'b0; in_res = 32'hDEAD_BEEF;
    in_nan = 1'b1; in_exp_overflow = 1'b1; in_zero = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_left", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: got %h expected none", out_res);
        end else begin
          e = sb.pop_front();
          chk("out_res", out_res, e[34:3]);
          chk("out_flags", {29'b0, out_flags}, {29'b0, e[2:0]});
        end
        run_len  = prev_del ? run_len + 1 : 1;
        prev_del = 1'b1;
      end else begin
        prev_del = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_cnt_total", cnt_total, 0);
    @(posedge clk); #1;

    // Pass-through with one-cycle latency
    send(32'h4040_0000, 0, 0, 0, 32'h4040_0000);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_out_res", out_res, 32'h4040_0000);
    @(posedge clk); #1;
    chk("lat_valid_drop", out_valid, 0);

    // Canonicalisation
    send(32'hFFC1_2345, 1, 0, 0, 32'h7FC0_0000);
    send(32'h8123_4567, 0, 1, 0, 32'hFF80_0000);
    send(32'h8000_0001, 1, 0, 1, 32'h7FC0_0000);
    send(32'h8000_0001, 0, 0, 1, 32'h8000_0000);
    send(32'h0000_0001, 0, 1, 1, 32'h7F80_0000);
    wait_drain();

    // Backpressure: A and B fill the buffer, C must wait
    out_ready = 1'b0;
    send(32'h0000_0001, 0, 0, 0, 32'h0000_0001);
    send(32'h0000_0002, 0, 0, 0, 32'h0000_0002);
    in_valid = 1'b1; in_res = 32'h0000_0003;
    in_nan = 1'b0; in_exp_overflow = 1'b0; in_zero = 1'b0;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_res", out_res, 32'h0000_0001);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h0000_0003, 0, 0, 0, 32'h0000_0003);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;

    // Streaming: 100 consecutive deliveries
    for (int i = 0; i < 100; i++)
      send(32'h3F80_0000 + i, 0, 0, 0, 32'h3F80_0000 + i);
    wait_drain();
    chk("stream_run_len", run_len, 100);

    // Sticky and counters
    clr_sticky = 1'b1; clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0; clr_cnt = 1'b0;
    chk("clr_sticky0", sticky, 0);
    chk("clr_cnt_total0", cnt_total, 0);
    for (int i = 0; i < 5; i++)
      send(32'h7F80_0001, 1, 0, 0, 32'h7FC0_0000);
    chk("cnt_nan_sat", cnt_nan, exp_cnt(3));
    chk("cnt_total_sat", cnt_total, exp_cnt(3));
    chk("cnt_ovf_idle", cnt_ovf, 0);
    chk("cnt_zero_idle", cnt_zero, 0);
    chk("sticky_nan", sticky, 3'b100);
    clr_sticky = 1'b1;
    send(32'h0000_0001, 0, 1, 0, 32'h7F80_0000);
    clr_sticky = 1'b0;
    chk("sticky_set_wins", sticky, 3'b010);
    chk("cnt_ovf_one", cnt_ovf, exp_cnt(1));
    wait_drain();
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_cnt_nan", cnt_nan, 0);
    chk("clr_cnt_ovf", cnt_ovf, 0);
    chk("clr_cnt_total", cnt_total, 0);
    chk("sticky_kept", sticky, 3'b010);

    // Asynchronous reset with the buffer full
    out_ready = 1'b0;
    send(32'h0000_0011, 0, 0, 0, 32'h0000_0011);
    send(32'h0000_0022, 0, 0, 0, 32'h0000_0022);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_sticky", sticky, 0);
    chk("arst_out_res", out_res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h4049_0FDB, 0, 0, 0, 32'h4049_0FDB);
    chk("post_rst_valid", out_valid, 1);
    wait_drain();
    chk("post_rst_idle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
